// File: rtl/ramb4_s2_fifo_ctrl.sv
// rtl/ramb4_s2_fifo_ctrl.sv - single-clock FIFO controller driving a 2048x2 dual-port block RAM
module ramb4_s2_fifo_ctrl #(
    parameter int ADDR_W     = 11,
    parameter int AFULL_LVL  = 2040,
    parameter int AEMPTY_LVL = 8
) (
    input  logic              CLKA,
    input  logic              RSTB,
    input  logic              wr_en,
    input  logic [1:0]        wr_data,
    input  logic              rd_en,
    output logic [1:0]        rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic [ADDR_W-1:0] ram_addra,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [1:0]        ram_dia,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic              ram_enb,
    output logic              ram_web,
    output logic              ram_rstb,
    input  logic [1:0]        ram_dob
);

    localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_LVL);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push_ok, pop_ok;

    // Flags come only from the registered occupancy, never from pointer compares.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

    // Requests are masked during reset so the RAM sees no enables.
    assign push_ok = wr_en & ~full & ~RSTB;
    assign pop_ok  = rd_en & ~empty & ~RSTB;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + ADDR_W'(push_ok);
        rd_ptr_d    = rd_ptr_q + ADDR_W'(pop_ok);
        count_d     = count_q + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
        rd_valid_d  = pop_ok;
        overflow_d  = wr_en & full;
        underflow_d = rd_en & empty;
        if (RSTB) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            rd_valid_d  = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLKA) begin
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
        rd_valid_q  <= rd_valid_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
    end

    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // The RAM registers port B itself, so read data is a straight pass-through.
    assign rd_data   = ram_dob;

    assign ram_addra = wr_ptr_q;
    assign ram_ena   = push_ok;
    assign ram_wea   = push_ok;
    assign ram_dia   = wr_data;
    assign ram_addrb = rd_ptr_q;
    assign ram_enb   = pop_ok;
    assign ram_web   = 1'b0;
    assign ram_rstb  = RSTB;

endmodule

// File: tb/tb_ramb4_s2_fifo_ctrl.sv
// tb/tb_ramb4_s2_fifo_ctrl.sv - self-checking bench for ramb4_s2_fifo_ctrl with a behavioural block RAM
module tb_ramb4_s2_fifo_ctrl;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;

    logic              CLKA = 1'b0;
    logic              RSTB = 1'b1;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_data = 2'd0;
    logic              rd_en = 1'b0;
    logic [1:0]        rd_data;
    logic              rd_valid, full, empty, almost_full, almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow, underflow;
    logic [ADDR_W-1:0] ram_addra, ram_addrb;
    logic              ram_ena, ram_wea, ram_enb, ram_web, ram_rstb;
    logic [1:0]        ram_dia;
    logic [1:0]        ram_dob;

    ramb4_s2_fifo_ctrl #(.ADDR_W(ADDR_W), .AFULL_LVL(2040), .AEMPTY_LVL(8)) dut (
        .CLKA(CLKA), .RSTB(RSTB), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .ram_addra(ram_addra),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_dia(ram_dia), .ram_addrb(ram_addrb),
        .ram_enb(ram_enb), .ram_web(ram_web), .ram_rstb(ram_rstb), .ram_dob(ram_dob)
    );

    always #5 CLKA = ~CLKA;

    // Behavioural 2048x2 dual-port RAM with registered port-B output.
    logic [1:0] mem [DEPTH];
    always @(posedge CLKA) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_rstb) ram_dob <= 2'd0;
        else if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    int total = 0;
    int bad   = 0;

    int         m_cnt = 0;
    int         m_wptr = 0;
    int         m_rptr = 0;
    logic [1:0] contents [$];
    logic [1:0] expect_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags();
        chk("count", 32'(count), 32'(m_cnt));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("full", 32'(full), 32'(m_cnt == DEPTH));
        chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 8));
        chk("almost_full", 32'(almost_full), 32'(m_cnt >= 2040));
    endtask

    // One clock of stimulus; model decides acceptance from pre-edge state.
    task automatic cycle(input logic w, input logic [1:0] d, input logic r);
        bit p_ok, q_ok;
        wr_en = w; wr_data = d; rd_en = r;
        p_ok = w && (m_cnt != DEPTH);
        q_ok = r && (m_cnt != 0);
        #1;
        chk("ram_ena", 32'(ram_ena), 32'(p_ok));
        chk("ram_enb", 32'(ram_enb), 32'(q_ok));
        if (p_ok) chk("ram_addra", 32'(ram_addra), 32'(m_wptr));
        if (q_ok) chk("ram_addrb", 32'(ram_addrb), 32'(m_rptr));
        @(posedge CLKA);
        if (p_ok) begin
            contents.push_back(d);
            m_wptr = (m_wptr + 1) % DEPTH;
            m_cnt++;
        end
        if (q_ok) begin
            expect_q.push_back(contents.pop_front());
            m_rptr = (m_rptr + 1) % DEPTH;
            m_cnt--;
        end
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(q_ok));
        if (rd_valid) begin
            if (expect_q.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'd0);
            else chk("rd_data", 32'(rd_data), 32'(expect_q.pop_front()));
        end
        chk("overflow", 32'(overflow), 32'(w && !p_ok));
        chk("underflow", 32'(underflow), 32'(r && !q_ok));
        chk_flags();
    endtask

    task automatic do_reset(input logic w, input logic r);
        RSTB = 1'b1; wr_en = w; rd_en = r; wr_data = 2'd3;
        #1;
        chk("rst_ram_ena", 32'(ram_ena), 32'd0);
        chk("rst_ram_wea", 32'(ram_wea), 32'd0);
        chk("rst_ram_enb", 32'(ram_enb), 32'd0);
        chk("rst_ram_rstb", 32'(ram_rstb), 32'd1);
        @(posedge CLKA); #1;
        RSTB = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        m_cnt = 0; m_wptr = 0; m_rptr = 0;
        contents.delete(); expect_q.delete();
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_web", 32'(ram_web), 32'd0);
        chk_flags();
    endtask

    typedef struct {
        logic       w;
        logic [1:0] d;
        logic       r;
        logic       e_valid;
        logic [1:0] e_data;
        int         e_count;
        logic       e_empty;
        logic       e_udf;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // Tests 1 and 3: hand-computed vectors from a fresh reset.
        vecs[0]  = '{1, 2'd0, 0, 0, 2'd0, 1, 0, 0};
        vecs[1]  = '{1, 2'd1, 0, 0, 2'd0, 2, 0, 0};
        vecs[2]  = '{1, 2'd2, 0, 0, 2'd0, 3, 0, 0};
        vecs[3]  = '{1, 2'd3, 0, 0, 2'd0, 4, 0, 0};
        vecs[4]  = '{0, 2'd0, 1, 1, 2'd0, 3, 0, 0};
        vecs[5]  = '{0, 2'd0, 1, 1, 2'd1, 2, 0, 0};
        vecs[6]  = '{0, 2'd0, 1, 1, 2'd2, 1, 0, 0};
        vecs[7]  = '{0, 2'd0, 1, 1, 2'd3, 0, 1, 0};
        vecs[8]  = '{0, 2'd0, 1, 0, 2'd0, 0, 1, 1};
        vecs[9]  = '{1, 2'd2, 1, 0, 2'd0, 1, 0, 1};
        vecs[10] = '{0, 2'd0, 1, 1, 2'd2, 0, 1, 0};

        repeat (2) @(posedge CLKA);
        #1;
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            wr_en = vecs[i].w; wr_data = vecs[i].d; rd_en = vecs[i].r;
            @(posedge CLKA); #1;
            chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_udf", i), 32'(underflow), 32'(vecs[i].e_udf));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
        end
        wr_en = 0; rd_en = 0;

        // Test 2: fill to full, overflow, drain in order.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 2'(i), 1'b0);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd2048);
        cycle(1'b1, 2'd1, 1'b0);
        chk("t2_ovf", 32'(overflow), 32'd1);
        cycle(1'b1, 2'd2, 1'b1);
        chk("t2_ovf_with_pop", 32'(overflow), 32'd1);
        cycle(1'b0, 2'd0, 1'b0);
        chk("t2_ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 2'd0, 1'b1);
        chk("t2_drained", 32'(empty), 32'd1);

        // Test 4: steady state at count 5, pointers wrap.
        for (int i = 0; i < 5; i++) cycle(1'b1, 2'(i), 1'b0);
        for (int i = 0; i < 3000; i++) cycle(1'b1, 2'(i + 5), 1'b1);
        chk("t4_count", 32'(count), 32'd5);

        // Test 5: thresholds.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 2'(i), 1'b0);
        chk("t5_aempty_9", 32'(almost_empty), 32'd0);
        for (int i = 9; i < 2040; i++) cycle(1'b1, 2'(i), 1'b0);
        chk("t5_afull_2040", 32'(almost_full), 32'd1);
        cycle(1'b0, 2'd0, 1'b1);
        chk("t5_afull_2039", 32'(almost_full), 32'd0);

        // Test 6: reset with occupancy and a pop requested, then fresh data.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 2'(i), 1'b0);
        cycle(1'b0, 2'd0, 1'b1);
        do_reset(1'b1, 1'b1);
        cycle(1'b1, 2'd3, 1'b0);
        cycle(1'b1, 2'd2, 1'b1);
        cycle(1'b0, 2'd0, 1'b1);
        cycle(1'b0, 2'd0, 1'b0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_leftover", 32'(expect_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
